cordic_rotator: RTL and testbench
=================================

Name: cordic_rotator

Overview:
- Pipelined rotation-mode CORDIC that computes a vector rotation on IEEE-754 single-precision operands.
- With x0 = K ≈ 0.607253 (0x3F1B74EE), y0 = 0 and angle z0, it produces x = cos(z0), y = sin(z0) and z = the residual angle.
- Serves as the trig engine of the datapath.
- Accepts one new operand set every clock cycle.

Parameters:
- ITER, 16, number of CORDIC micro-rotation stages (1..24).
- FRAC, 29, fractional bits of the internal signed 32-bit fixed-point format (Q2.29, range ±4).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- io_in_x0  in  32  initial x, IEEE-754 single.
- io_in_y0  in  32  initial y, IEEE-754 single.
- io_in_z0  in  32  rotation angle in radians, IEEE-754 single; valid range |z0| ≤ π/2.
- io_out_x  out  32  rotated x (cos), IEEE-754 single.
- io_out_y  out  32  rotated y (sin), IEEE-754 single.
- io_out_z  out  32  residual angle, IEEE-754 single.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - While reset = 0, all pipeline registers clear and all outputs read 0x00000000.
  - Data in flight at reset assertion is discarded.
- Handshake: none. Inputs are sampled on every rising edge, and outputs are continuously valid data of the sample taken ITER+2 cycles earlier.
- Stage 0 (input convert, registered): float → signed Q2.29 for x0, y0, z0.
  - Exponent < −FRAC, zero or denormal → 0.
  - |value| ≥ 4, Inf or NaN → saturate to ±(2^31−1) / −2^31 according to sign.
  - Mantissa is truncated toward zero.
- Stages 1..ITER (one register each), for i = 0..ITER−1:
  - d = +1 if z ≥ 0, else −1.
  - x' = x − d·(y >>> i); y' = y + d·(x >>> i); z' = z − d·atan(2^−i).
  - Shifts are arithmetic. Add/sub wraps in 32 bits; overflow cannot occur for legal inputs.
- Stage ITER+1 (output convert, registered): signed fixed → float.
  - Sign-magnitude conversion, leading-zero count, normalize, mantissa truncated toward zero.
  - Fixed zero → +0.0 (0x00000000).
  - −2^31 converts exactly to −4.0.
- Latency: exactly ITER+2 clock cycles from input sample to output; throughput 1 per cycle.
- Accuracy:
  - For |z0| ≤ π/2 and x0 = K, y0 = 0: |x − cos z0| and |y − sin z0| ≤ 2^−(ITER−2).
  - |z_out| ≤ atan(2^−(ITER−1)) plus quantization.
- Inputs with |z0| > π/2 are not range-reduced; the result is undefined but must not hang or produce X.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- When defined:
  - Stage 0 additionally multiplies converted x0 and y0 by the constant K = 0.6072529350 (Q2.29 constant, product truncated).
  - The caller then supplies x0 = 1.0 (0x3F800000) to obtain cos/sin.
  - Latency remains ITER+2.
- When undefined: no scaling is applied; outputs carry the CORDIC gain (≈1.64676·|(x0,y0)|).

Decomposition:
- Package cordic_pkg holds:
  - Fixed-point width and FRAC constants.
  - The atan(2^−i) table for i = 0..23 in Q2.29.
  - The gain constant K.
  - Float field-position constants.
- Natural sub-module: cordic_stage (one parameterised micro-rotation stage, shift index as parameter), instantiated ITER times via generate.
- Float↔fixed conversion may be functions in cordic_pkg.

Test Plan:
- Reset: hold reset = 0 with random inputs → all outputs 0x00000000. Deassert → first non-zero result appears exactly ITER+2 cycles after the first sampled input.
- π/4: x0 = 0x3F1B74EE, y0 = 0, z0 = 0x3F490FDB → after ITER+2 cycles, x ≈ y ≈ 0.707107 (0x3F3504F3), within 2^−14; z_out within ±2^−14.
- Endpoints (same x0, y0):
  - z0 = 0x00000000 → x ≈ 1.0, y ≈ 0.0.
  - z0 = 0xBFC90FDB (−π/2) → x ≈ 0.0, y ≈ −1.0.
  - z0 = 0x3FC90FDB → y ≈ +1.0.
  - All within 2^−14.
- Streaming sweep: 129 angles from −π/2 to +π/2 in steps of π/128, one per cycle back-to-back (e.g. z0 = 0xBF6231D6 → cos 0.634393, sin −0.773010; z0 = 0x3E490FD8 → cos 0.980785, sin 0.195090). Each output matches its input ITER+2 cycles earlier, error < 1e−4.
- Reset mid-stream: assert reset asynchronously between clock edges → outputs go to 0 immediately. After release, no stale pre-reset results appear.
- CORDIC_GAIN_COMP_EN defined: x0 = 0x3F800000, y0 = 0, z0 = 0x3F490FDB → x ≈ y ≈ 0.707107. With the macro undefined, the same stimulus gives x ≈ y ≈ 1.16443.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared fixed-point constants, atan table, gain constant and the
// float<->fixed conversion helpers used by the rotation pipeline.
`default_nettype none

package cordic_pkg;

  localparam int FIX_W       = 32;
  localparam int CORDIC_FRAC = 29;
  localparam int ATAN_N      = 24;

  localparam int FLT_SIGN    = 31;
  localparam int FLT_EXP_MSB = 30;
  localparam int FLT_EXP_LSB = 23;
  localparam int FLT_MAN_MSB = 22;
  localparam int FLT_MAN_W   = 23;
  localparam int FLT_BIAS    = 127;

  // 1/prod(sqrt(1+2^-2i)) in Q2.29
  localparam logic signed [FIX_W-1:0] GAIN_K = 32'sd326016437;

  // atan(2^-i) in Q2.29, rounded to nearest
  localparam logic signed [FIX_W-1:0] ATAN_TABLE [ATAN_N] = '{
    32'sd421657428, 32'sd248918915, 32'sd131521918, 32'sd66762579,
    32'sd33510843,  32'sd16771758,  32'sd8387925,   32'sd4194219,
    32'sd2097141,   32'sd1048575,   32'sd524288,    32'sd262144,
    32'sd131072,    32'sd65536,     32'sd32768,     32'sd16384,
    32'sd8192,      32'sd4096,      32'sd2048,      32'sd1024,
    32'sd512,       32'sd256,       32'sd128,       32'sd64
  };

  function automatic logic signed [FIX_W-1:0] float_to_fix(input logic [31:0] f, input int frac);
    logic [7:0]              e;
    logic [FIX_W-1:0]        mag;
    logic signed [FIX_W-1:0] res;
    int                      sh;
    e   = f[FLT_EXP_MSB:FLT_EXP_LSB];
    mag = {{(FIX_W-FLT_MAN_W-1){1'b0}}, 1'b1, f[FLT_MAN_MSB:0]};
    sh  = int'(e) - (FLT_BIAS + FLT_MAN_W) + frac;
    if (e == 8'd0 || int'(e) < FLT_BIAS - frac) begin
      res = '0;
    end else if (e == 8'hFF || int'(e) >= FLT_BIAS + FIX_W - 1 - frac) begin
      res = f[FLT_SIGN] ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
    end else begin
      mag = (sh >= 0) ? (mag << sh) : (mag >> (-sh));
      res = f[FLT_SIGN] ? -$signed(mag) : $signed(mag);
    end
    return res;
  endfunction

  function automatic logic [31:0] fix_to_float(input logic signed [FIX_W-1:0] v, input int frac);
    logic [FIX_W-1:0] mag;
    logic [FIX_W-1:0] norm;
    logic [7:0]       e;
    int               msb;
    mag = v[FIX_W-1] ? (~v + 1'b1) : v;
    msb = 0;
    for (int i = 0; i < FIX_W; i++) begin
      if (mag[i]) msb = i;
    end
    norm = mag << (FIX_W - 1 - msb);
    e    = 8'(msb - frac + FLT_BIAS);
    return (v == '0) ? 32'h0 : {v[FIX_W-1], e, norm[FIX_W-2 -: FLT_MAN_W]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_stage.sv
// cordic_stage: one registered rotation-mode micro-rotation with shift index SHIFT.
`default_nettype none

module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT = 0,
  parameter int FRAC  = CORDIC_FRAC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [FIX_W-1:0] x_i,
  input  logic signed [FIX_W-1:0] y_i,
  input  logic signed [FIX_W-1:0] z_i,
  output logic signed [FIX_W-1:0] x_o,
  output logic signed [FIX_W-1:0] y_o,
  output logic signed [FIX_W-1:0] z_o
);

  localparam logic signed [FIX_W-1:0] ATAN_I = ATAN_TABLE[SHIFT] >>> (CORDIC_FRAC - FRAC);

  logic signed [FIX_W-1:0] x_d, y_d, z_d;
  logic signed [FIX_W-1:0] x_q, y_q, z_q;

  always_comb begin
    if (!z_i[FIX_W-1]) begin
      x_d = x_i - (y_i >>> SHIFT);
      y_d = y_i + (x_i >>> SHIFT);
      z_d = z_i - ATAN_I;
    end else begin
      x_d = x_i + (y_i >>> SHIFT);
      y_d = y_i - (x_i >>> SHIFT);
      z_d = z_i + ATAN_I;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign z_o = z_q;

endmodule

`default_nettype wire

// File: rtl/cordic_rotator.sv
// cordic_rotator: pipelined float-in/float-out rotation CORDIC, latency ITER+2.
// Define CORDIC_GAIN_COMP_EN to pre-scale x0/y0 by K in the input stage.
`default_nettype none

module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int ITER = 16,
  parameter int FRAC = CORDIC_FRAC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] io_in_x0,
  input  logic [31:0] io_in_y0,
  input  logic [31:0] io_in_z0,
  output logic [31:0] io_out_x,
  output logic [31:0] io_out_y,
  output logic [31:0] io_out_z
);

  logic signed [FIX_W-1:0] x_d, y_d, z_d;
  logic signed [FIX_W-1:0] x_q, y_q, z_q;
  logic signed [FIX_W-1:0] x_pipe [ITER+1];
  logic signed [FIX_W-1:0] y_pipe [ITER+1];
  logic signed [FIX_W-1:0] z_pipe [ITER+1];
  logic [31:0]             out_x_q, out_y_q, out_z_q;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [FIX_W-1:0] K_FIX = GAIN_K >>> (CORDIC_FRAC - FRAC);
  logic signed [FIX_W-1:0]   x_fix, y_fix;
  logic signed [2*FIX_W-1:0] x_prod, y_prod;

  always_comb begin
    x_fix  = float_to_fix(io_in_x0, FRAC);
    y_fix  = float_to_fix(io_in_y0, FRAC);
    x_prod = (2*FIX_W)'(x_fix) * (2*FIX_W)'(K_FIX);
    y_prod = (2*FIX_W)'(y_fix) * (2*FIX_W)'(K_FIX);
    x_d    = x_prod[FRAC +: FIX_W];
    y_d    = y_prod[FRAC +: FIX_W];
    z_d    = float_to_fix(io_in_z0, FRAC);
  end
`else
  always_comb begin
    x_d = float_to_fix(io_in_x0, FRAC);
    y_d = float_to_fix(io_in_y0, FRAC);
    z_d = float_to_fix(io_in_z0, FRAC);
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x_pipe[0] = x_q;
  assign y_pipe[0] = y_q;
  assign z_pipe[0] = z_q;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_stage #(
      .SHIFT (i),
      .FRAC  (FRAC)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .x_i   (x_pipe[i]),
      .y_i   (y_pipe[i]),
      .z_i   (z_pipe[i]),
      .x_o   (x_pipe[i+1]),
      .y_o   (y_pipe[i+1]),
      .z_o   (z_pipe[i+1])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_x_q <= '0;
      out_y_q <= '0;
      out_z_q <= '0;
    end else begin
      out_x_q <= fix_to_float(x_pipe[ITER], FRAC);
      out_y_q <= fix_to_float(y_pipe[ITER], FRAC);
      out_z_q <= fix_to_float(z_pipe[ITER], FRAC);
    end
  end

  assign io_out_x = out_x_q;
  assign io_out_y = out_y_q;
  assign io_out_z = out_z_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed checks of reset, latency, accuracy and streaming.
`default_nettype none

module tb_cordic_rotator;

  localparam int  ITER = 16;
  localparam real TOL  = 1.0 / 16384.0;
  localparam real STOL = 1.0e-4;
  localparam real PI   = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [31:0] X0_UNIT = 32'h3F800000;
`else
  localparam logic [31:0] X0_UNIT = 32'h3F1B74EE;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] io_in_x0, io_in_y0, io_in_z0;
  logic [31:0] io_out_x, io_out_y, io_out_z;
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] sweep_z [129];

  always #5 clock = ~clock;

  cordic_rotator #(
    .ITER (ITER),
    .FRAC (29)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io_in_x0 (io_in_x0),
    .io_in_y0 (io_in_y0),
    .io_in_z0 (io_in_z0),
    .io_out_x (io_out_x),
    .io_out_y (io_out_y),
    .io_out_z (io_out_z)
  );

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real r;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    int          e;
    d = $realtobits(v);
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0) return 32'h0;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  task automatic chk_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input real exp, input real tol);
    real  got;
    logic ok;
    got = f2r(obs);
    ok  = ((got - exp) <= tol) && ((exp - got) <= tol);
    n_total++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s: observed %h (%f) expected %f within %g", tag, obs, got, exp, tol);
  endtask

  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    @(negedge clock);
    io_in_x0 = x;
    io_in_y0 = y;
    io_in_z0 = z;
    repeat (ITER + 2) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int  idx;
    real zr;
    reset    = 1'b1;
    io_in_x0 = '0;
    io_in_y0 = '0;
    io_in_z0 = '0;
    #1 reset = 1'b0;

    repeat (4) begin
      @(negedge clock);
      io_in_x0 = $urandom;
      io_in_y0 = $urandom;
      io_in_z0 = $urandom;
    end
    @(negedge clock);
    chk_bits("rst_x", io_out_x, 32'h0);
    chk_bits("rst_y", io_out_y, 32'h0);
    chk_bits("rst_z", io_out_z, 32'h0);

    // release with pi/4 held; x/y must stay zero until the (ITER+2)th edge
    io_in_x0 = X0_UNIT;
    io_in_y0 = 32'h0;
    io_in_z0 = 32'h3F490FDB;
    reset    = 1'b1;
    for (int k = 1; k <= ITER + 1; k++) begin
      @(negedge clock);
      chk_bits($sformatf("lat_x[%0d]", k), io_out_x, 32'h0);
      chk_bits($sformatf("lat_y[%0d]", k), io_out_y, 32'h0);
    end
    @(negedge clock);
    chk_near("pi4_x", io_out_x, 0.70710678, TOL);
    chk_near("pi4_y", io_out_y, 0.70710678, TOL);
    chk_near("pi4_z", io_out_z, 0.0, TOL);

    run_one(X0_UNIT, 32'h0, 32'h00000000);
    chk_near("zero_x", io_out_x, 1.0, TOL);
    chk_near("zero_y", io_out_y, 0.0, TOL);
    run_one(X0_UNIT, 32'h0, 32'hBFC90FDB);
    chk_near("mpi2_x", io_out_x, 0.0, TOL);
    chk_near("mpi2_y", io_out_y, -1.0, TOL);
    run_one(X0_UNIT, 32'h0, 32'h3FC90FDB);
    chk_near("ppi2_x", io_out_x, 0.0, TOL);
    chk_near("ppi2_y", io_out_y, 1.0, TOL);
    run_one(X0_UNIT, 32'h0, 32'hBF6231D6);
    chk_near("neg_x", io_out_x, 0.634393, TOL);
    chk_near("neg_y", io_out_y, -0.773010, TOL);
    run_one(X0_UNIT, 32'h0, 32'h3E490FD8);
    chk_near("pos_x", io_out_x, 0.980785, TOL);
    chk_near("pos_y", io_out_y, 0.195090, TOL);

    // back-to-back sweep: output at slot c belongs to input c-(ITER+2)
    io_in_x0 = X0_UNIT;
    io_in_y0 = 32'h0;
    for (int c = 0; c < 129 + ITER + 2; c++) begin
      @(negedge clock);
      if (c >= ITER + 2) begin
        idx = c - ITER - 2;
        zr  = f2r(sweep_z[idx]);
        chk_near($sformatf("sweep_x[%0d]", idx), io_out_x, $cos(zr), STOL);
        chk_near($sformatf("sweep_y[%0d]", idx), io_out_y, $sin(zr), STOL);
      end
      if (c < 129) begin
        sweep_z[c] = r2f(-PI / 2.0 + c * PI / 128.0);
        io_in_z0   = sweep_z[c];
      end
    end

    // asynchronous reset between edges with a full pipeline
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk_bits("mid_x", io_out_x, 32'h0);
    chk_bits("mid_y", io_out_y, 32'h0);
    chk_bits("mid_z", io_out_z, 32'h0);
    @(negedge clock);
    io_in_x0 = X0_UNIT;
    io_in_y0 = 32'h0;
    io_in_z0 = 32'h0;
    reset    = 1'b1;
    for (int k = 1; k <= ITER + 1; k++) begin
      @(negedge clock);
      chk_bits($sformatf("stale_x[%0d]", k), io_out_x, 32'h0);
      chk_bits($sformatf("stale_y[%0d]", k), io_out_y, 32'h0);
    end
    @(negedge clock);
    chk_near("post_x", io_out_x, 1.0, TOL);
    chk_near("post_y", io_out_y, 0.0, TOL);

    run_one(32'h3F800000, 32'h0, 32'h3F490FDB);
`ifdef CORDIC_GAIN_COMP_EN
    chk_near("unit_x", io_out_x, 0.70710678, TOL);
    chk_near("unit_y", io_out_y, 0.70710678, TOL);
`else
    chk_near("unit_x", io_out_x, 1.16443536, STOL);
    chk_near("unit_y", io_out_y, 1.16443536, STOL);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
